// File: rtl/adder_sub_recover.sv
// Recovers b = sum - a from a registered sum and one operand, CHUNK_WIDTH bits per cycle.
// Define ADDER_SUB_ONESHOT_EN to replace the chunked loop with one full-width subtraction.
module adder_sub_recover #(
   parameter int ADDER_WIDTH = 117,
   parameter int CHUNK_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDER_WIDTH:0]   sum,
   input  logic [ADDER_WIDTH-1:0] a,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDER_WIDTH-1:0] b,
   output logic                   range_err
);

   localparam int SW     = ADDER_WIDTH + 1;
   localparam int NCHUNK = (SW + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int PW     = NCHUNK * CHUNK_WIDTH;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // in_ready/out_valid depend on state only, never on the partner's signal.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t state;
   state_t state_nx;
   logic   accept;
   logic   calc_last;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = CALC;
         CALC:    if (calc_last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

`ifdef ADDER_SUB_ONESHOT_EN
   logic [SW-1:0] s_reg;
   logic [SW-1:0] a_reg;
   logic [SW:0]   full_diff;

   assign full_diff = {1'b0, s_reg} - {1'b0, a_reg};
   assign calc_last = 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_reg <= '0;
         a_reg <= '0;
      end else if (accept) begin
         s_reg <= sum;
         a_reg <= {1'b0, a};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         b         <= '0;
         range_err <= 1'b0;
      end else if (state == CALC) begin
         b         <= full_diff[ADDER_WIDTH-1:0];
         range_err <= full_diff[SW] | full_diff[ADDER_WIDTH];
      end
   end
`else
   // Operands shift right one chunk per cycle; the difference shifts in from the top,
   // so after NCHUNK cycles chunk 0 lands at bit 0 without any variable indexing.
   logic [PW-1:0]          s_sh;
   logic [PW-1:0]          a_sh;
   logic [PW-1:0]          res_sh;
   logic [PW-1:0]          res_nx;
   logic [CHUNK_WIDTH:0]   chunk_d;
   logic [IDXW-1:0]        idx;
   logic                   borrow;

   assign chunk_d   = {1'b0, s_sh[CHUNK_WIDTH-1:0]} - {1'b0, a_sh[CHUNK_WIDTH-1:0]}
                      - (CHUNK_WIDTH+1)'(borrow);
   assign res_nx    = (res_sh >> CHUNK_WIDTH) | (PW'(chunk_d[CHUNK_WIDTH-1:0]) << (PW - CHUNK_WIDTH));
   assign calc_last = (idx == IDXW'(NCHUNK - 1));

   // Zero padding above bit ADDER_WIDTH propagates the top borrow to the chunk borrow-out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_sh   <= '0;
         a_sh   <= '0;
         res_sh <= '0;
         idx    <= '0;
         borrow <= 1'b0;
      end else if (accept) begin
         s_sh   <= PW'(sum);
         a_sh   <= PW'(a);
         idx    <= '0;
         borrow <= 1'b0;
      end else if (state == CALC) begin
         s_sh   <= s_sh >> CHUNK_WIDTH;
         a_sh   <= a_sh >> CHUNK_WIDTH;
         res_sh <= res_nx;
         borrow <= chunk_d[CHUNK_WIDTH];
         idx    <= idx + IDXW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         b         <= '0;
         range_err <= 1'b0;
      end else if (state == CALC && calc_last) begin
         b         <= res_nx[ADDER_WIDTH-1:0];
         range_err <= chunk_d[CHUNK_WIDTH] | res_nx[ADDER_WIDTH];
      end
   end
`endif

endmodule

// File: tb/tb_adder_sub_recover.sv
// Bench for adder_sub_recover: directed cases plus random jobs checked through an expected queue.
module tb_adder_sub_recover;

  localparam int AW = 117;
  localparam int SW = AW + 1;
`ifdef ADDER_SUB_ONESHOT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = (SW + 31) / 32 + 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] sum = '0;
  logic [AW-1:0] a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] b;
  logic          range_err;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_exp;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            rand_ready = 1'b0;

  always #5 clk = ~clk;

  adder_sub_recover dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .range_err(range_err)
  );

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: true difference in plain integer terms; out of range if negative or >= 2^AW.
  function automatic logic [SW-1:0] model(input logic [SW-1:0] s, input logic [AW-1:0] x);
    logic [SW-1:0] xe;
    logic [SW-1:0] diff;
    logic          err;
    xe   = SW'(x);
    diff = s - xe;
    if (s >= xe) err = (diff >= (SW'(1) << AW));
    else         err = 1'b1;
    return {err, diff[AW-1:0]};
  endfunction

  function automatic logic [SW-1:0] rand_w();
    return SW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h expected none", {range_err, b});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {range_err, b}, mon_exp);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [SW-1:0] s, input logic [AW-1:0] x, input logic [SW-1:0] exp);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    sum = s;
    a = x;
    exp_q.push_back(exp);
    tick(1);
    in_valid = 1'b0;
    sum = rand_w();
    a = AW'(rand_w());
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick(1);
      t++;
    end
    check("drain", SW'(exp_q.size()), '0);
    tick(2);
  endtask

  initial begin
    int            cyc;
    logic [SW-1:0] s;
    logic [AW-1:0] x;
    logic [SW-1:0] e;
    logic [AW-1:0] ones;

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    check("rst_in_ready", SW'(in_ready), SW'(1));
    check("rst_out_valid", SW'(out_valid), '0);
    check("rst_b", SW'(b), '0);
    check("rst_range_err", SW'(range_err), '0);

    // Basic recovery with latency and return-to-idle
    out_ready = 1'b1;
    send(SW'(300), AW'(100), SW'(200));
    wait_valid(cyc);
    check("latency", SW'(cyc + 1), SW'(LAT));
    tick(1);
    check("post_hs_in_ready", SW'(in_ready), SW'(1));
    check("post_hs_out_valid", SW'(out_valid), '0);

    // Borrow across chunk 0/1 boundary
    send(SW'(1) << 32, AW'(1), SW'(32'hFFFF_FFFF));
    drain();

    // Underflow and overflow
    ones = '1;
    send(SW'(5), AW'(7), {1'b1, ones - AW'(1)});
    drain();
    send((SW'(1) << AW) + SW'(5), AW'(0), {1'b1, AW'(5)});
    drain();

    // Backpressure with an ignored in_valid pulse during CALC
    out_ready = 1'b0;
    s = rand_w();
    x = AW'(rand_w());
    e = model(s, x);
    send(s, x, e);
    in_valid = 1'b1;
    sum = rand_w();
    a = AW'(rand_w());
    tick(1);
    in_valid = 1'b0;
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      check("bp_result", {range_err, b}, e);
      check("bp_out_valid", SW'(out_valid), SW'(1));
      check("bp_in_ready", SW'(in_ready), '0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_release_out_valid", SW'(out_valid), '0);
    check("bp_release_in_ready", SW'(in_ready), SW'(1));
    drain();

    // Reset in the second CALC cycle abandons the job
    out_ready = 1'b0;
    s = rand_w();
    x = AW'(rand_w());
    send(s, x, model(s, x));
    tick(1);
    reset_n = 1'b0;
    tick(1);
    check("midrst_in_ready", SW'(in_ready), SW'(1));
    check("midrst_out_valid", SW'(out_valid), '0);
    check("midrst_b", SW'(b), '0);
    reset_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    send(SW'(10), AW'(3), SW'(7));
    drain();

    // Random jobs with random backpressure, biased toward the range boundaries
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s = rand_w();
      x = AW'(rand_w());
      case ($urandom_range(0, 3))
        0: ;
        1: x = s[AW-1:0];
        2: s = SW'(x) + SW'($urandom_range(0, 3)) - SW'($urandom_range(0, 3));
        default: s = SW'($urandom_range(0, 255));
      endcase
      send(s, x, model(s, x));
    end
    drain();
    rand_ready = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
